// File: rtl/spongent_cut_adapter.sv
// rtl/spongent_cut_adapter.sv - streams the autotest message into the Spongent core and collects its digest.
// Optional build macro CUT_ADAPTER_PAD_EN: adapter appends the 10* pad chunk itself.
module spongent_cut_adapter #(
  parameter int DATA_WIDTH = 64,
  parameter int N          = 88,
  parameter int R          = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rst_cut,
  input  logic [DATA_WIDTH-1:0] input_to_cut,
  output logic                  end_cut,
  output logic [N-1:0]          output_from_cut,
  output logic                  core_rst,
  output logic [R-1:0]          core_din,
  output logic                  core_din_valid,
  output logic                  core_din_last,
  input  logic                  core_din_ready,
  input  logic [R-1:0]          core_dout,
  input  logic                  core_dout_valid,
  output logic                  core_dout_ready
);

  localparam int IN_BEATS  = DATA_WIDTH / R;
  localparam int OUT_BEATS = N / R;
  localparam int CW        = $clog2(IN_BEATS + 1);
  localparam int OW        = $clog2(OUT_BEATS + 1);
  localparam logic [CW-1:0] IN_LAST  = CW'(IN_BEATS - 1);
  localparam logic [OW-1:0] OUT_LAST = OW'(OUT_BEATS - 1);

  if ((DATA_WIDTH % R) != 0 || (N % R) != 0) begin : g_bad_params
    $fatal(1, "spongent_cut_adapter: DATA_WIDTH and N must be multiples of R");
  end

`ifdef CUT_ADAPTER_PAD_EN
  typedef enum logic [2:0] {S_IDLE, S_ABSORB, S_PAD, S_SQUEEZE, S_DONE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_ABSORB, S_SQUEEZE, S_DONE} state_t;
`endif

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] msg_q, msg_d;
  logic [CW-1:0]         chunk_cnt_q, chunk_cnt_d;
  logic [OW-1:0]         out_cnt_q, out_cnt_d;
  logic [N-1:0]          digest_q, digest_d;

  assign core_rst        = rst | rst_cut;
  assign end_cut         = (state_q == S_DONE);
  assign output_from_cut = digest_q;

  always_comb begin
    state_d         = state_q;
    msg_d           = msg_q;
    chunk_cnt_d     = chunk_cnt_q;
    out_cnt_d       = out_cnt_q;
    digest_d        = digest_q;
    core_din        = msg_q[DATA_WIDTH-1 -: R];
    core_din_valid  = 1'b0;
    core_din_last   = 1'b0;
    core_dout_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Only reached with rst_cut low: the register reset overrides this load.
        msg_d       = input_to_cut;
        chunk_cnt_d = '0;
        out_cnt_d   = '0;
        state_d     = S_ABSORB;
      end
      S_ABSORB: begin
        core_din_valid = 1'b1;
`ifndef CUT_ADAPTER_PAD_EN
        core_din_last  = (chunk_cnt_q == IN_LAST);
`endif
        if (core_din_ready) begin
          msg_d       = msg_q << R;
          chunk_cnt_d = chunk_cnt_q + 1'b1;
          if (chunk_cnt_q == IN_LAST) begin
`ifdef CUT_ADAPTER_PAD_EN
            state_d = S_PAD;
`else
            state_d = S_SQUEEZE;
`endif
          end
        end
      end
`ifdef CUT_ADAPTER_PAD_EN
      S_PAD: begin
        core_din       = {1'b1, {(R-1){1'b0}}};
        core_din_valid = 1'b1;
        core_din_last  = 1'b1;
        if (core_din_ready) state_d = S_SQUEEZE;
      end
`endif
      S_SQUEEZE: begin
        core_dout_ready = 1'b1;
        if (core_dout_valid) begin
          digest_d  = (digest_q << R) | N'(core_dout);
          out_cnt_d = out_cnt_q + 1'b1;
          if (out_cnt_q == OUT_LAST) state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || rst_cut) begin
      state_q     <= S_IDLE;
      msg_q       <= '0;
      chunk_cnt_q <= '0;
      out_cnt_q   <= '0;
      digest_q    <= '0;
    end else begin
      state_q     <= state_d;
      msg_q       <= msg_d;
      chunk_cnt_q <= chunk_cnt_d;
      out_cnt_q   <= out_cnt_d;
      digest_q    <= digest_d;
    end
  end

endmodule

// File: tb/tb_spongent_cut_adapter.sv
// tb/tb_spongent_cut_adapter.sv - directed and randomized bench for spongent_cut_adapter.
// Expected chunks and digests come from a queue-based model of the message/digest byte order.
module tb_spongent_cut_adapter;
  localparam int DW = 64;
  localparam int N  = 88;
  localparam int R  = 8;
  localparam int IB = DW / R;
  localparam int OB = N / R;

  logic          clk = 1'b0;
  logic          rst;
  logic          rst_cut;
  logic [DW-1:0] input_to_cut;
  logic          end_cut;
  logic [N-1:0]  output_from_cut;
  logic          core_rst;
  logic [R-1:0]  core_din;
  logic          core_din_valid;
  logic          core_din_last;
  logic          core_din_ready;
  logic [R-1:0]  core_dout;
  logic          core_dout_valid;
  logic          core_dout_ready;

  int checks = 0;
  int errors = 0;
  logic [N-1:0] last_digest;
  localparam logic [DW-1:0] T1_MSG    = 64'h0123456789ABCDEF;
  localparam logic [N-1:0]  T1_DIGEST = 88'h112233445566778899AABB;

  spongent_cut_adapter #(.DATA_WIDTH(DW), .N(N), .R(R)) dut (
    .clk(clk), .rst(rst), .rst_cut(rst_cut), .input_to_cut(input_to_cut),
    .end_cut(end_cut), .output_from_cut(output_from_cut), .core_rst(core_rst),
    .core_din(core_din), .core_din_valid(core_din_valid), .core_din_last(core_din_last),
    .core_din_ready(core_din_ready), .core_dout(core_dout), .core_dout_valid(core_dout_valid),
    .core_dout_ready(core_dout_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
    end
  endtask

  // One full message run; abort_after >= 0 pulses rst_cut after that many squeeze beats.
  task automatic run_msg(input logic [DW-1:0] msg, input bit fixed_beats, input int stall_idx,
                         input int stall_pct, input int gap_min, input int gap_max,
                         input bit spurious, input int abort_after);
    logic [R-1:0] exp_in[$];
    logic [R-1:0] beats[$];
    logic [R-1:0] pad;
    logic [N-1:0] partial;
    int idx, budget, stall_used, gap;
    bit rdy;
    pad = '0;
    pad[R-1] = 1'b1;
    for (int k = 0; k < IB; k++) exp_in.push_back(msg[DW-1-k*R -: R]);
`ifdef CUT_ADAPTER_PAD_EN
    exp_in.push_back(pad);
`endif
    for (int j = 0; j < OB; j++)
      beats.push_back(fixed_beats ? R'((j + 1) * 17) : R'($urandom));

    rst_cut = 1'b1; input_to_cut = msg; core_din_ready = 1'b0; core_dout_valid = 1'b0;
    @(negedge clk);
    chk("hold_core_rst", core_rst, 1);
    chk("hold_end_cut", end_cut, 0);
    chk("hold_din_valid", core_din_valid, 0);
    chk("hold_digest", output_from_cut, 0);
    rst_cut = 1'b0;
    @(negedge clk);
    input_to_cut = ~msg;
    idx = 0; budget = 0; stall_used = 0;
    while (idx < exp_in.size() && budget < 200) begin
      chk("din_valid", core_din_valid, 1);
      chk("din", core_din, exp_in[idx]);
      chk("din_last", core_din_last, (idx == exp_in.size() - 1));
      chk("dout_ready_absorb", core_dout_ready, 0);
      chk("digest_absorb", output_from_cut, 0);
      if (idx == stall_idx && stall_used < 3) begin
        rdy = 1'b0;
        stall_used++;
      end else begin
        rdy = ($urandom_range(99) >= stall_pct);
      end
      core_din_ready  = rdy;
      core_dout_valid = spurious & $urandom_range(1);
      core_dout       = R'($urandom);
      @(negedge clk);
      if (rdy) idx++;
      budget++;
    end
    chk("absorb_beats", idx, exp_in.size());
    core_din_ready = 1'b0; core_dout_valid = 1'b0;
    partial = '0;
    for (int j = 0; j < OB; j++) begin
      if (j == abort_after) begin
        rst_cut = 1'b1;
        @(negedge clk);
        chk("abort_end_cut", end_cut, 0);
        chk("abort_digest", output_from_cut, 0);
        chk("abort_core_rst", core_rst, 1);
        chk("abort_dout_ready", core_dout_ready, 0);
        return;
      end
      gap = $urandom_range(gap_max, gap_min);
      repeat (gap) begin
        chk("gap_dout_ready", core_dout_ready, 1);
        chk("gap_digest", output_from_cut, partial);
        @(negedge clk);
      end
      chk("sq_dout_ready", core_dout_ready, 1);
      chk("sq_din_valid", core_din_valid, 0);
      chk("sq_end_cut", end_cut, 0);
      chk("sq_digest", output_from_cut, partial);
      core_dout_valid = 1'b1; core_dout = beats[j];
      @(negedge clk);
      core_dout_valid = 1'b0;
      partial = (partial << R) | N'(beats[j]);
    end
    chk("done_end_cut", end_cut, 1);
    chk("done_digest", output_from_cut, partial);
    last_digest = partial;
  endtask

  task automatic hold_done(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      input_to_cut    = {$urandom, $urandom};
      core_dout_valid = $urandom_range(1);
      core_dout       = R'($urandom);
      core_din_ready  = $urandom_range(1);
      @(negedge clk);
      chk("hold_done_end_cut", end_cut, 1);
      chk("hold_done_digest", output_from_cut, last_digest);
    end
  endtask

  initial begin
    rst = 1'b1; rst_cut = 1'b0; input_to_cut = '0;
    core_din_ready = 1'b0; core_dout = '0; core_dout_valid = 1'b0;
    last_digest = '0;
    repeat (3) @(negedge clk);
    chk("rst_end_cut", end_cut, 0);
    chk("rst_digest", output_from_cut, 0);
    chk("rst_din_valid", core_din_valid, 0);
    chk("rst_din_last", core_din_last, 0);
    chk("rst_dout_ready", core_dout_ready, 0);
    chk("rst_core_rst", core_rst, 1);
    rst = 1'b0; rst_cut = 1'b1;
    @(negedge clk);

    run_msg(T1_MSG, 1'b1, -1, 0, 0, 0, 1'b0, -1);
    chk("t1_digest", last_digest, T1_DIGEST);

    run_msg(T1_MSG, 1'b1, 2, 0, 0, 0, 1'b0, -1);
    chk("t2_digest", last_digest, T1_DIGEST);

    run_msg(T1_MSG, 1'b1, -1, 0, 0, 0, 1'b0, 5);
    run_msg(T1_MSG, 1'b1, -1, 0, 0, 0, 1'b0, -1);
    chk("t3_rerun_digest", last_digest, T1_DIGEST);

    run_msg(T1_MSG, 1'b1, -1, 0, 2, 2, 1'b1, -1);
    chk("t4_digest", last_digest, T1_DIGEST);

    hold_done(100);

    for (int it = 0; it < 6; it++)
      run_msg({$urandom, $urandom}, 1'b0, -1, 30, 0, 3, 1'b1, (it == 2) ? 4 : -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/spongent_cut_adapter.md
Name: spongent_cut_adapter

Overview:
Sits between the autotest FSM and the Spongent hash core (the CUT). Takes the wide message register and the CUT reset from the FSM and streams the message into the core in rate-sized chunks over a valid/ready handshake. It then collects the squeezed digest into an N-bit register and raises end_cut, which the FSM uses to capture output_from_cut and stop its timeout counter.

Parameters:
DATA_WIDTH, 64, message width in bits; must be a multiple of R.
N, 88, digest width in bits; must be a multiple of R.
R, 8, sponge rate / chunk width in bits. Elaboration fails if DATA_WIDTH%R or N%R is non-zero.

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
rst_cut  in  1  CUT reset/hold from autotest FSM; active-high, level
input_to_cut  in  DATA_WIDTH  message; byte k of the SD block maps to bits [8k+7:8k]
end_cut  out  1  digest complete; level, held until rst_cut or rst
output_from_cut  out  N  collected digest; stable while end_cut=1
core_rst  out  1  reset to hash core; equals rst | rst_cut (combinational)
core_din  out  R  absorb chunk
core_din_valid  out  1  absorb chunk valid
core_din_last  out  1  marks final absorb chunk
core_din_ready  in  1  core accepts chunk
core_dout  in  R  squeeze chunk
core_dout_valid  in  1  squeeze chunk valid
core_dout_ready  out  1  adapter accepts squeeze chunk

Behaviour:
- Reset (rst=1 or rst_cut=1, sampled at posedge): state IDLE; end_cut=0; output_from_cut=0; core_din_valid=0; core_dout_ready=0; counters=0. rst_cut has the same effect as rst in every state, so an assertion mid-operation aborts to IDLE on the next edge.
- States: IDLE, ABSORB, PAD, SQUEEZE, DONE.
- IDLE: on the first edge with rst_cut=0, load input_to_cut into msg_shift and clear chunk_cnt and out_cnt. Next state is ABSORB.
- ABSORB:
  - core_din = msg_shift[DATA_WIDTH-1 -: R]; chunks go out MSB-first.
  - core_din_valid=1.
  - A beat is transferred on valid&ready. On each beat, msg_shift shifts left by R and chunk_cnt increments.
  - core_din and valid are held while ready=0.
  - After beat DATA_WIDTH/R-1 transfers, go to PAD (or SQUEEZE, see optional feature).
- PAD: core_din = {1'b1, (R-1){1'b0}} (0x80 for R=8), core_din_valid=1, core_din_last=1. On transfer, go to SQUEEZE.
- SQUEEZE:
  - core_dout_ready=1.
  - On each dout_valid beat, output_from_cut <= {output_from_cut[N-R-1:0], core_dout}, so the first beat ends up in the MSBs. out_cnt increments.
  - After beat N/R-1, go to DONE.
  - core_dout_valid arriving in any other state is ignored.
- DONE: end_cut=1, output_from_cut frozen. Stays in DONE until rst_cut or rst.
- Latency: end_cut rises on the edge that accepts the last squeeze beat (registered; visible the following cycle). With an always-ready core, the first core_din_valid appears 1 cycle after rst_cut falls.
- Counters: chunk_cnt is $clog2(DATA_WIDTH/R+1) bits; out_cnt is $clog2(N/R+1) bits. Neither counter wraps; transitions are taken at terminal count.
- core_din_last=0 in every state except the final absorb beat.
- input_to_cut changes after the IDLE load are ignored.

Optional Feature:
Macro CUT_ADAPTER_PAD_EN.
- Defined: the PAD state exists and the adapter appends the 10* padding chunk; core_din_last is asserted only on the pad beat.
- Not defined: PAD is removed. core_din_last is asserted on data chunk DATA_WIDTH/R-1, and ABSORB goes directly to SQUEEZE; the core is expected to pad internally.
- All other behaviour is identical in both builds.

Test Plan:
- Test 1, stimulus: defaults, PAD_EN defined, core always ready; rst_cut falls with input_to_cut=0x0123456789ABCDEF; core returns squeeze beats 0x11,0x22,...,0xBB. Required response: core_din sequence 01,23,45,67,89,AB,CD,EF,80 with last only on 80; output_from_cut=0x112233445566778899AABB; end_cut=1 one cycle after the 11th beat.
- Test 2, stimulus: core_din_ready low for 3 cycles during beat 0x45. Required response: core_din stays 0x45 with valid=1 for all stalled cycles; no chunk is skipped or duplicated.
- Test 3, stimulus: rst_cut pulsed high during SQUEEZE after 5 beats. Required response: next cycle end_cut=0, output_from_cut=0, core_rst=1. A rerun with the same message reproduces the Test 1 digest.
- Test 4, stimulus: core_dout_valid pulses during ABSORB, then gaps of 2 cycles between squeeze beats. Required response: the ABSORB-phase pulses are ignored; the digest is the same as Test 1.
- Test 5, stimulus: build without PAD_EN, same message as Test 1. Required response: 8 beats, last on 0xEF, no 0x80 beat; SQUEEZE is entered the cycle after the 0xEF transfer.
- Test 6, stimulus: hold in DONE for 100 cycles while changing input_to_cut. Required response: end_cut stays 1 and output_from_cut is unchanged.
